// File: rtl/rename_s1.sv
// Rename stage 1: single-entry pipeline register holding the stage-0 rename bundle,
// intra-bundle dependency override mux, dispatch handshake, and renamed-bundle counter.
module rename_s1 #(
  parameter int PW    = 7,
  parameter int CNT_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              s0_vld_i,
  output logic              s0_rdy_o,
  input  logic [3:0]        s0_inst_vld_i,
  input  logic [3:0]        s0_ard_vld_i,
  input  logic [4*PW-1:0]   s0_prs1_i,
  input  logic [4*PW-1:0]   s0_prs2_i,
  input  logic [4*PW-1:0]   s0_prd_old_i,
  input  logic [4*PW-1:0]   s0_prd_new_i,
  input  logic [7:0]        s0_rs1_sel_i,
  input  logic [7:0]        s0_rs2_sel_i,
  input  logic [7:0]        s0_rd_sel_i,
  output logic              dis_vld_o,
  input  logic              dis_rdy_i,
  output logic [3:0]        dis_inst_vld_o,
  output logic [4*PW-1:0]   dis_prs1_o,
  output logic [4*PW-1:0]   dis_prs2_o,
  output logic [4*PW-1:0]   dis_prd_o,
  output logic [4*PW-1:0]   dis_prd_old_o,
  output logic [CNT_W-1:0]  ren_cnt_o
);

  logic              vld_q, vld_d;
  logic [3:0]        inst_vld_q, ard_vld_q;
  logic [4*PW-1:0]   prs1_q, prs2_q, prd_old_q, prd_new_q;
  logic [7:0]        rs1_sel_q, rs2_sel_q, rd_sel_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              load, payload_en, hs;

  // A select pointing at a later slot is illegal; fall back to the slot's own lookup.
  function automatic logic [1:0] eff_sel(input logic [1:0] sel, input logic [1:0] slot);
    return (sel > slot) ? slot : sel;
  endfunction

  assign s0_rdy_o   = ~vld_q | dis_rdy_i;
  assign load       = s0_vld_i & s0_rdy_o;
  assign payload_en = load & ~flush_i;
  assign hs         = vld_q & dis_rdy_i;

  always_comb begin
    vld_d = vld_q;
    if (flush_i)        vld_d = 1'b0;
    else if (load)      vld_d = 1'b1;
    else if (dis_rdy_i) vld_d = 1'b0;
  end

  assign cnt_d = cnt_q + CNT_W'(hs);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_q      <= 1'b0;
      cnt_q      <= '0;
      inst_vld_q <= '0;
      ard_vld_q  <= '0;
      prs1_q     <= '0;
      prs2_q     <= '0;
      prd_old_q  <= '0;
      prd_new_q  <= '0;
      rs1_sel_q  <= '0;
      rs2_sel_q  <= '0;
      rd_sel_q   <= '0;
    end else begin
      vld_q <= vld_d;
      cnt_q <= cnt_d;
      if (payload_en) begin
        inst_vld_q <= s0_inst_vld_i;
        ard_vld_q  <= s0_ard_vld_i;
        prs1_q     <= s0_prs1_i;
        prs2_q     <= s0_prs2_i;
        prd_old_q  <= s0_prd_old_i;
        prd_new_q  <= s0_prd_new_i;
        rs1_sel_q  <= s0_rs1_sel_i;
        rs2_sel_q  <= s0_rs2_sel_i;
        rd_sel_q   <= s0_rd_sel_i;
      end
    end
  end

  logic [PW-1:0] new_a [4];

  for (genvar g = 0; g < 4; g++) begin : g_new
    assign new_a[g] = prd_new_q[g*PW +: PW];
  end

  for (genvar g = 0; g < 4; g++) begin : g_slot
    localparam logic [1:0] SLOT = 2'(g);
    logic [1:0]    s1, s2, sd;
    logic [PW-1:0] old_sel;

    assign s1 = eff_sel(rs1_sel_q[2*g +: 2], SLOT);
    assign s2 = eff_sel(rs2_sel_q[2*g +: 2], SLOT);
    assign sd = eff_sel(rd_sel_q[2*g +: 2], SLOT);

    assign dis_prs1_o[g*PW +: PW] = (s1 == SLOT) ? prs1_q[g*PW +: PW] : new_a[s1];
    assign dis_prs2_o[g*PW +: PW] = (s2 == SLOT) ? prs2_q[g*PW +: PW] : new_a[s2];
    // WAW: an earlier slot's new mapping is what this slot frees at commit.
    assign old_sel = (sd == SLOT) ? prd_old_q[g*PW +: PW] : new_a[sd];

    assign dis_prd_o[g*PW +: PW]     = ard_vld_q[g] ? new_a[g] : '0;
    assign dis_prd_old_o[g*PW +: PW] = ard_vld_q[g] ? old_sel  : '0;
  end

  for (genvar g = 0; g < 3; g++) begin : g_chk
    localparam logic [1:0] SLOT = 2'(g);
    a_sel_legal: assert property (@(posedge clk_i) disable iff (rst_i)
      vld_q |-> (rs1_sel_q[2*g +: 2] <= SLOT) && (rs2_sel_q[2*g +: 2] <= SLOT)
             && (rd_sel_q[2*g +: 2] <= SLOT));
  end

  assign dis_vld_o      = vld_q;
  assign dis_inst_vld_o = inst_vld_q & {4{vld_q}};
  assign ren_cnt_o      = cnt_q;

endmodule

// File: tb/tb_rename_s1.sv
// Testbench for rename_s1: directed cases plus a scoreboard of expected renamed bundles
// pushed on accept and compared on dispatch handshake.
module tb_rename_s1;
  localparam int PW = 7;
  localparam int CNT_W = 32;

  logic            clk = 1'b0;
  logic            rst, flush, s0_vld, s0_rdy, dis_vld, dis_rdy;
  logic [3:0]      inst_vld, ard_vld, dis_iv;
  logic [4*PW-1:0] prs1, prs2, prd_old, prd_new;
  logic [7:0]      rs1_sel, rs2_sel, rd_sel;
  logic [4*PW-1:0] d_prs1, d_prs2, d_prd, d_prd_old;
  logic [CNT_W-1:0] ren_cnt;

  always #5 clk = ~clk;

  rename_s1 #(.PW(PW), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .s0_vld_i(s0_vld), .s0_rdy_o(s0_rdy),
    .s0_inst_vld_i(inst_vld), .s0_ard_vld_i(ard_vld),
    .s0_prs1_i(prs1), .s0_prs2_i(prs2), .s0_prd_old_i(prd_old), .s0_prd_new_i(prd_new),
    .s0_rs1_sel_i(rs1_sel), .s0_rs2_sel_i(rs2_sel), .s0_rd_sel_i(rd_sel),
    .dis_vld_o(dis_vld), .dis_rdy_i(dis_rdy), .dis_inst_vld_o(dis_iv),
    .dis_prs1_o(d_prs1), .dis_prs2_o(d_prs2), .dis_prd_o(d_prd), .dis_prd_old_o(d_prd_old),
    .ren_cnt_o(ren_cnt)
  );

  typedef struct packed {
    logic [3:0]      iv;
    logic [4*PW-1:0] p1, p2, pd, po;
  } exp_t;

  exp_t  sb_q[$];
  int    n_chk = 0, n_fail = 0;
  logic [CNT_W-1:0] exp_cnt = '0;
  bit    mon_en = 1'b0;
  bit    snap_vld = 1'b0;
  exp_t  snap;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [4*PW-1:0] p4(input int a, input int b, input int c, input int d);
    return {PW'(d), PW'(c), PW'(b), PW'(a)};
  endfunction

  // Reference model of the override mux from the current stage-0 inputs.
  function automatic exp_t model();
    exp_t e;
    e.iv = inst_vld;
    for (int k = 0; k < 4; k++) begin
      int a, b, c;
      a = rs1_sel[2*k +: 2]; if (a > k) a = k;
      b = rs2_sel[2*k +: 2]; if (b > k) b = k;
      c = rd_sel[2*k +: 2];  if (c > k) c = k;
      e.p1[k*PW +: PW] = (a == k) ? prs1[k*PW +: PW] : prd_new[a*PW +: PW];
      e.p2[k*PW +: PW] = (b == k) ? prs2[k*PW +: PW] : prd_new[b*PW +: PW];
      e.pd[k*PW +: PW] = ard_vld[k] ? prd_new[k*PW +: PW] : '0;
      e.po[k*PW +: PW] = !ard_vld[k] ? '0 :
                         (c == k) ? prd_old[k*PW +: PW] : prd_new[c*PW +: PW];
    end
    return e;
  endfunction

  task automatic rand_bundle();
    prs1     = 28'($urandom);
    prs2     = 28'($urandom);
    prd_old  = 28'($urandom);
    prd_new  = 28'($urandom);
    inst_vld = 4'($urandom);
    ard_vld  = 4'($urandom);
    rs1_sel  = {2'($urandom_range(0, 3)), 2'($urandom_range(0, 2)), 2'($urandom_range(0, 1)), 2'b00};
    rs2_sel  = {2'($urandom_range(0, 3)), 2'($urandom_range(0, 2)), 2'($urandom_range(0, 1)), 2'b00};
    rd_sel   = {2'($urandom_range(0, 3)), 2'($urandom_range(0, 2)), 2'($urandom_range(0, 1)), 2'b00};
  endtask

  // Offer one bundle for a single cycle (caller guarantees s0_rdy), then sample next negedge.
  task automatic load1();
    @(posedge clk); #1 s0_vld = 1'b1;
    @(posedge clk); #1 s0_vld = 1'b0;
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      exp_t e;
      check_eq("cnt", 64'(ren_cnt), 64'(exp_cnt));
      check_eq("dis_vld", 64'(dis_vld), 64'(sb_q.size() != 0));
      check_eq("s0_rdy", 64'(s0_rdy), 64'((sb_q.size() == 0) || dis_rdy));
      if (!dis_vld) check_eq("iv_idle", 64'(dis_iv), 64'd0);
      if (snap_vld && dis_vld) begin
        check_eq("stable_iv", 64'(dis_iv), 64'(snap.iv));
        check_eq("stable_prs1", 64'(d_prs1), 64'(snap.p1));
        check_eq("stable_prd_old", 64'(d_prd_old), 64'(snap.po));
      end
      snap_vld = dis_vld && !dis_rdy && !rst && !flush;
      snap = '{dis_iv, d_prs1, d_prs2, d_prd, d_prd_old};
      if (dis_vld && dis_rdy && sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check_eq("sb_iv", 64'(dis_iv), 64'(e.iv));
        check_eq("sb_prs1", 64'(d_prs1), 64'(e.p1));
        check_eq("sb_prs2", 64'(d_prs2), 64'(e.p2));
        check_eq("sb_prd", 64'(d_prd), 64'(e.pd));
        check_eq("sb_prd_old", 64'(d_prd_old), 64'(e.po));
      end
      if (rst) begin
        exp_cnt = '0;
        sb_q.delete();
      end else begin
        if (dis_vld && dis_rdy) exp_cnt = exp_cnt + 1'b1;
        if (flush) sb_q.delete();
        else if (s0_vld && s0_rdy) sb_q.push_back(model());
      end
    end
  end

  initial begin
    rst = 1'b1; flush = 1'b0; s0_vld = 1'b0; dis_rdy = 1'b0;
    inst_vld = '0; ard_vld = '0; prs1 = '0; prs2 = '0; prd_old = '0; prd_new = '0;
    rs1_sel = '0; rs2_sel = '0; rd_sel = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("rst_vld", 64'(dis_vld), 64'd0);
    check_eq("rst_rdy", 64'(s0_rdy), 64'd1);
    check_eq("rst_iv", 64'(dis_iv), 64'd0);
    check_eq("rst_prs1", 64'(d_prs1), 64'd0);
    check_eq("rst_prs2", 64'(d_prs2), 64'd0);
    check_eq("rst_prd", 64'(d_prd), 64'd0);
    check_eq("rst_prd_old", 64'(d_prd_old), 64'd0);
    check_eq("rst_cnt", 64'(ren_cnt), 64'd0);
    @(posedge clk); #1 mon_en = 1'b1;

    // Independent bundle
    dis_rdy = 1'b1;
    prs1 = p4(10, 11, 12, 13); prs2 = p4(5, 6, 7, 8);
    prd_old = p4(1, 2, 3, 4);  prd_new = p4(30, 31, 32, 33);
    rs1_sel = 8'he4; rs2_sel = 8'he4; rd_sel = 8'he4;
    inst_vld = 4'hf; ard_vld = 4'hf;
    load1();
    check_eq("indep_vld", 64'(dis_vld), 64'd1);
    check_eq("indep_prs1", 64'(d_prs1), 64'(p4(10, 11, 12, 13)));
    check_eq("indep_cnt0", 64'(ren_cnt), 64'd0);
    @(negedge clk);
    check_eq("indep_cnt1", 64'(ren_cnt), 64'd1);

    // Chain override and WAW old mapping
    prd_new = p4(40, 41, 42, 43); prd_old = p4(20, 20, 20, 20);
    rs1_sel = 8'h90; rd_sel = 8'h90;
    load1();
    check_eq("chain_prs1", 64'(d_prs1), 64'(p4(10, 40, 41, 42)));
    check_eq("waw_prd_old", 64'(d_prd_old), 64'(p4(20, 40, 41, 42)));
    check_eq("waw_prd", 64'(d_prd), 64'(p4(40, 41, 42, 43)));
    ard_vld = 4'b1011;
    load1();
    check_eq("noard_prd", 64'(d_prd), 64'(p4(40, 41, 0, 43)));
    check_eq("noard_prd_old", 64'(d_prd_old), 64'(p4(20, 40, 0, 42)));

    // Backpressure with a second bundle offered
    @(posedge clk); #1 dis_rdy = 1'b0; rand_bundle(); s0_vld = 1'b1;
    @(posedge clk); #1 rand_bundle();
    repeat (3) begin
      @(negedge clk);
      check_eq("bp_rdy", 64'(s0_rdy), 64'd0);
      check_eq("bp_vld", 64'(dis_vld), 64'd1);
    end
    @(posedge clk); #1 dis_rdy = 1'b1;
    @(posedge clk); #1 s0_vld = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("bp_cnt", 64'(ren_cnt), 64'd5);

    // Flush with an incoming bundle, then flush of a held bundle
    @(posedge clk); #1 rand_bundle(); s0_vld = 1'b1; flush = 1'b1;
    @(posedge clk); #1 s0_vld = 1'b0; flush = 1'b0;
    @(negedge clk);
    check_eq("flush_in_vld", 64'(dis_vld), 64'd0);
    check_eq("flush_in_cnt", 64'(ren_cnt), 64'd5);
    @(posedge clk); #1 dis_rdy = 1'b0; rand_bundle(); s0_vld = 1'b1;
    @(posedge clk); #1 s0_vld = 1'b0; flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0; dis_rdy = 1'b1;
    @(negedge clk);
    check_eq("flush_held_vld", 64'(dis_vld), 64'd0);
    check_eq("flush_held_cnt", 64'(ren_cnt), 64'd5);

    // Back-to-back stream at full throughput
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) begin
      rand_bundle(); s0_vld = 1'b1;
      @(posedge clk); #1;
    end
    s0_vld = 1'b0;
    @(negedge clk);
    check_eq("stream_cnt7", 64'(ren_cnt), 64'd12);
    check_eq("stream_vld", 64'(dis_vld), 64'd1);
    @(negedge clk);
    check_eq("stream_cnt8", 64'(ren_cnt), 64'd13);

    // Reset while a bundle is stalled
    @(posedge clk); #1 dis_rdy = 1'b0; rand_bundle(); s0_vld = 1'b1;
    @(posedge clk); #1 s0_vld = 1'b0; rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_eq("rstst_vld", 64'(dis_vld), 64'd0);
    check_eq("rstst_cnt", 64'(ren_cnt), 64'd0);
    check_eq("rstst_rdy", 64'(s0_rdy), 64'd1);
    check_eq("rstst_prs1", 64'(d_prs1), 64'd0);

    @(posedge clk); #1 dis_rdy = 1'b1;
    repeat (2) @(posedge clk);
    #1 mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/rename_s1.md
Name: rename_s1

Overview:
- Rename stage 1 of the 4-wide rename pipeline.
- Registers the rename stage-0 bundle: RAT source/old-dest lookups, freshly allocated physical destinations, and the intra-bundle dependency select codes.
- Applies the dependency-override mux so later slots see physical mappings created earlier in the same bundle.
- Presents the renamed bundle to dispatch under a valid/ready handshake, with flush and a renamed-bundle counter.

Parameters:
- PW, 7, physical register tag width (128-entry PRF)
- CNT_W, 32, width of the renamed-bundle counter

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- flush_i  in  1  pipeline flush (mispredict/exception); kills the held bundle
- s0_vld_i  in  1  stage-0 bundle valid
- s0_rdy_o  out  1  stage 1 can accept a bundle this cycle
- s0_inst_vld_i  in  4  per-slot instruction valid
- s0_ard_vld_i  in  4  per-slot architectural destination valid
- s0_prs1_i  in  4*PW  RAT lookup of rs1, slot k at [k*PW +: PW]
- s0_prs2_i  in  4*PW  RAT lookup of rs2
- s0_prd_old_i  in  4*PW  RAT lookup of rd (previous mapping)
- s0_prd_new_i  in  4*PW  free-list allocated physical dest per slot
- s0_rs1_sel_i  in  8  dependency select for rs1, slot k at [2k+1:2k]
- s0_rs2_sel_i  in  8  dependency select for rs2
- s0_rd_sel_i  in  8  dependency select for rd (WAW)
- dis_vld_o  out  1  renamed bundle valid to dispatch
- dis_rdy_i  in  1  dispatch accepts bundle
- dis_inst_vld_o  out  4  per-slot valid
- dis_prs1_o  out  4*PW  final physical rs1
- dis_prs2_o  out  4*PW  final physical rs2
- dis_prd_o  out  4*PW  physical dest (0 when ard_vld=0)
- dis_prd_old_o  out  4*PW  mapping to free at commit (0 when ard_vld=0)
- ren_cnt_o  out  CNT_W  count of bundles handed to dispatch

Behaviour:
- Single-entry pipeline register; all stage-0 inputs are captured into *_q on load = s0_vld_i & s0_rdy_o.
- s0_rdy_o = !vld_q | dis_rdy_i. It is combinational and permits full throughput: load and drain can occur in the same cycle.
- vld_q next value:
  - rst_i or flush_i -> 0.
  - else load -> 1.
  - else dis_rdy_i -> 0.
  - else hold.
- flush_i has priority over a same-cycle load; the incoming bundle is dropped.
- dis_vld_o = vld_q. Latency is 1 cycle from accepted s0 bundle to dis_vld_o.
- While dis_vld_o=1 and dis_rdy_i=0, every dis_* output is held stable.
- Outputs are combinational from the registered state. For slot k, with sel = the slot's 2-bit select field:
  - dis_prs1[k] = (sel==k) ? prs1_q[k] : prd_new_q[sel]. dis_prs2 uses the same rule.
  - dis_prd_old[k] = (rd_sel==k) ? prd_old_q[k] : prd_new_q[rd_sel]. This is the WAW chain: the earlier slot's new mapping is the one freed.
  - dis_prd[k] = prd_new_q[k].
  - dis_prd and dis_prd_old are forced to 0 when ard_vld_q[k]=0.
- Selects with value > k are illegal. For slot k the block treats them as k (no override); SVA flags the condition in simulation.
- Slot 0 selects are ignored; slot 0 always uses its own lookups.
- dis_inst_vld_o = inst_vld_q & {4{vld_q}}.
- ren_cnt_o:
  - Increments by 1 on dis_vld_o & dis_rdy_i.
  - Wraps modulo 2^CNT_W.
  - Resets to 0 on rst_i only; it is not cleared by flush.
- Reset values:
  - vld_q=0, all payload registers 0.
  - Therefore dis_vld_o=0, dis_inst_vld_o=0, dis_* buses 0, s0_rdy_o=1.
- Reset asserted mid-stall: the bundle is discarded. No handshake completes that cycle and the counter does not increment.

Test Plan:
- Independent bundle: prs1={10,11,12,13}, all selects = own slot, dis_rdy_i=1 -> next cycle dis_vld_o=1, dis_prs1={10,11,12,13}, ren_cnt_o 0->1.
- Chain override: prd_new={40,41,42,43}, rs1_sel={slot1:0, slot2:1, slot3:2} -> dis_prs1 slot1=40, slot2=41, slot3=42.
- WAW old mapping: prd_old={20,20,20,20}, rd_sel={0,0,1,2}, all ard_vld=1 -> dis_prd_old={20,40,41,42}. Repeat with ard_vld[2]=0 -> slot2 prd and prd_old = 0.
- Backpressure: dis_rdy_i=0 for 3 cycles with a bundle held and a second s0 bundle offered -> s0_rdy_o=0 and outputs stable. dis_rdy_i=1 -> second bundle appears next cycle, ren_cnt_o +2 total.
- Flush: flush_i=1 together with s0_vld_i=1 -> dis_vld_o=0 next cycle and counter unchanged. A back-to-back stream at dis_rdy_i=1 sustains 1 bundle/cycle.
- Reset mid-stall: rst_i=1 with vld_q=1, dis_rdy_i=0 -> next cycle dis_vld_o=0, ren_cnt_o=0, s0_rdy_o=1.
